// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for a multi-cycle RV32I datapath (PC, IR/old_pc, regfile,
//   ALU, unified memory). It decodes the IR opcode in each state and drives
//   every write enable, mux select and ALU class. It also detects halt:
//   an ECALL with x17 == HALT_CODE stops the core.
//
//   State | meaning
//   IF   0 | fetch: mem[PC] -> IR, PC -> old_pc
//   ID   1 | decode, PC <- PC+4, halt detection
//   EX   2 | execute / address calc / branch compare / jump
//   MEM  3 | data memory access (LD read, ST write)
//   WB   4 | register writeback (R, I, LD)
//   BR   5 | taken branch: PC <- old_pc + imm
//   HALT 7 | core halted until reset (6 unused, recovers to IF)
//
// Ports
//   clk, reset (sync, active-low), opcode (IR[6:0]), x17, bcond,
//   mem_ready (only with MULTICYCLE_CTRL_MEM_WAIT_EN),
//   pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, wb_sel,
//   alu_src_a, alu_src_b, alu_op, state (debug), is_halted.
//
// Configuration macro: MULTICYCLE_CTRL_MEM_WAIT_EN adds mem_ready; IF and MEM
//   then hold until memory reports completion.
module multicycle_ctrl #(
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned HALT_CODE  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [DATA_WIDTH-1:0] x17,
    input  logic                  bcond,
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    input  logic                  mem_ready,
`endif
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  i_or_d,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [1:0]            wb_sel,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            alu_op,
    output logic [2:0]            state,
    output logic                  is_halted
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_BR   = 3'd5,
        S_HALT = 3'd7
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    state_t state_q;
    state_t state_nxt;
    logic   halted_q;
    logic   mem_done;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IF;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            // HALT is only reachable from ID and is sticky, so this rises exactly on ID->HALT
            halted_q <= halted_q | (state_nxt == S_HALT);
        end
    end

    always_comb begin
        state_nxt = S_IF;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        i_or_d    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;

        case (state_q)
            S_IF: begin
                mem_read  = 1'b1;
                ir_write  = mem_done;
                state_nxt = mem_done ? S_ID : S_IF;
            end
            S_ID: begin
                alu_src_b = 2'b01;
                if (opcode == OP_ECALL && x17 == DATA_WIDTH'(HALT_CODE)) begin
                    state_nxt = S_HALT;
                end else begin
                    pc_write = 1'b1;
                    case (opcode)
                        OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR: state_nxt = S_EX;
                        default:                                          state_nxt = S_IF;
                    endcase
                end
            end
            S_EX: begin
                case (opcode)
                    OP_R: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b10;
                        state_nxt = S_WB;
                    end
                    OP_I: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        alu_op    = 2'b11;
                        state_nxt = S_WB;
                    end
                    OP_LD, OP_ST: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_nxt = S_MEM;
                    end
                    OP_BR: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b01;
                        state_nxt = bcond ? S_BR : S_IF;
                    end
                    OP_JAL, OP_JALR: begin
                        // rd takes PC (already old_pc+4) on the same edge PC gets the target
                        alu_src_a = (opcode == OP_JALR);
                        alu_src_b = 2'b10;
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        state_nxt = S_IF;
                    end
                    default: state_nxt = S_IF;
                endcase
            end
            S_MEM: begin
                i_or_d = 1'b1;
                case (opcode)
                    OP_LD: begin
                        mem_read  = 1'b1;
                        state_nxt = mem_done ? S_WB : S_MEM;
                    end
                    OP_ST: begin
                        mem_write = 1'b1;
                        state_nxt = mem_done ? S_IF : S_MEM;
                    end
                    default: state_nxt = S_IF;
                endcase
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (opcode == OP_LD) ? 2'b01 : 2'b00;
                state_nxt = S_IF;
            end
            S_BR: begin
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_nxt = S_IF;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IF;
        endcase

        // an in-flight instruction aborted by reset must not write anything
        if (!reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign state     = state_q;
    assign is_halted = halted_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;
    localparam logic [6:0] OP_BAD   = 7'b0000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [31:0] x17;
    logic        bcond;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    logic        mem_ready;
`endif
    logic        pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0]  wb_sel, alu_src_b, alu_op;
    logic        alu_src_a;
    logic [2:0]  state;
    logic        is_halted;

    int checks = 0;
    int errors = 0;

    int          exp_st[$];
    int          exp_npc, exp_nreg, exp_nrd, exp_nwr;
    logic [1:0]  exp_wbs;
    logic [4:0]  exp_exctl;

    always #5 clk = ~clk;

    multicycle_ctrl #(.DATA_WIDTH(32), .HALT_CODE(10)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .x17(x17), .bcond(bcond),
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .state(state), .is_halted(is_halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {pc_write, ir_write, mem_read, mem_write, reg_write};
    endfunction

    // Reference: an instruction is a visit list of states plus pulse counts.
    task automatic model(input logic [6:0] op, input logic bc);
        bit jump, mem, rd;
        jump = (op == OP_JAL) || (op == OP_JALR);
        exp_st = {0, 1};
        case (op)
            OP_R, OP_I: exp_st = {exp_st, 2, 4};
            OP_LD:      exp_st = {exp_st, 2, 3, 4};
            OP_ST:      exp_st = {exp_st, 2, 3};
            OP_BR:      exp_st = bc ? {exp_st, 2, 5} : {exp_st, 2};
            OP_JAL, OP_JALR: exp_st = {exp_st, 2};
            default: ;
        endcase
        mem      = (op == OP_LD);
        rd       = (op == OP_R) || (op == OP_I) || mem || jump;
        exp_npc  = 1 + int'(jump) + int'(op == OP_BR && bc);
        exp_nreg = int'(rd);
        exp_nrd  = 1 + int'(mem);
        exp_nwr  = int'(op == OP_ST);
        exp_wbs  = mem ? 2'b01 : (jump ? 2'b10 : 2'b00);
        case (op)
            OP_R:          exp_exctl = 5'b1_00_10;
            OP_I:          exp_exctl = 5'b1_10_11;
            OP_BR:         exp_exctl = 5'b1_00_01;
            OP_JAL:        exp_exctl = 5'b0_10_00;
            default:       exp_exctl = 5'b1_10_00;
        endcase
    endtask

    // Called just after a posedge with the DUT in IF.
    task automatic run_instr(input logic [6:0] op, input logic bc, input logic [31:0] x);
        int npc = 0, nreg = 0, nrd = 0, nwr = 0, nir = 0;
        logic [1:0] wbs = 2'b00;
        opcode = op; bcond = bc; x17 = x;
        model(op, bc);
        foreach (exp_st[i]) begin
            @(negedge clk);
            chk("state", 32'(state), 32'(exp_st[i]));
            chk("is_halted_run", 32'(is_halted), 0);
            case (exp_st[i])
                1: chk("id_ctl", {alu_src_a, alu_src_b, alu_op}, 5'b0_01_00);
                2: chk("ex_ctl", {alu_src_a, alu_src_b, alu_op}, exp_exctl);
                3: chk("mem_i_or_d", 32'(i_or_d), 1);
                5: chk("br_ctl", {alu_src_a, alu_src_b, alu_op}, 5'b0_10_00);
                default: chk("if_i_or_d", 32'(i_or_d), 0);
            endcase
            npc  += int'(pc_write);
            nreg += int'(reg_write);
            nrd  += int'(mem_read);
            nwr  += int'(mem_write);
            nir  += int'(ir_write);
            if (reg_write) wbs = wb_sel;
            @(posedge clk); #1;
        end
        chk("pc_write_count",  32'(npc),  32'(exp_npc));
        chk("reg_write_count", 32'(nreg), 32'(exp_nreg));
        chk("mem_read_count",  32'(nrd),  32'(exp_nrd));
        chk("mem_write_count", 32'(nwr),  32'(exp_nwr));
        chk("ir_write_count",  32'(nir),  1);
        chk("wb_sel",          32'(wbs),  32'(exp_wbs));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_strobes", 32'(strobes()), 0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        chk("reset_state", 32'(state), 0);
        chk("reset_halted", 32'(is_halted), 0);
    endtask

    initial begin
        logic [6:0] ops [9];
        logic [31:0] rx;
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_ECALL, OP_BAD};
        reset = 1'b0; opcode = OP_R; x17 = 32'd0; bcond = 1'b0;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        @(posedge clk); #1;
        do_reset();

        run_instr(OP_R, 1'b0, 32'd0);
        run_instr(OP_LD, 1'b0, 32'd0);
        run_instr(OP_BR, 1'b1, 32'd0);
        run_instr(OP_BR, 1'b0, 32'd0);
        run_instr(OP_ECALL, 1'b0, 32'd9);
        run_instr(OP_JAL, 1'b0, 32'd0);
        run_instr(OP_JALR, 1'b1, 32'd0);
        run_instr(OP_ST, 1'b0, 32'd0);
        run_instr(OP_I, 1'b1, 32'd10);
        run_instr(OP_BAD, 1'b0, 32'd10);

        for (int n = 0; n < 60; n++) begin
            rx = $urandom;
            if (rx == 32'd10) rx = 32'd11;
            run_instr(ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), rx);
        end

        // reset while a store is in MEM
        opcode = OP_ST; bcond = 1'b0; x17 = 32'd0;
        repeat (3) begin @(posedge clk); #1; end
        chk("st_mem_state", 32'(state), 3);
        chk("st_mem_write", 32'(mem_write), 1);
        reset = 1'b0; #1;
        chk("st_abort_write", 32'(mem_write), 0);
        chk("st_abort_strobes", 32'(strobes()), 0);
        @(posedge clk); #1;
        chk("st_abort_state", 32'(state), 0);
        chk("st_abort_halted", 32'(is_halted), 0);
        reset = 1'b1;
        run_instr(OP_R, 1'b0, 32'd0);

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        opcode = OP_R; mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("wait_state", 32'(state), 0);
            chk("wait_ir_write", 32'(ir_write), 0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("wait_ir_write_go", 32'(ir_write), 1);
        @(posedge clk); #1;
        chk("wait_state_go", 32'(state), 1);
        do_reset();
`endif

        // halting ECALL
        opcode = OP_ECALL; x17 = 32'd10; bcond = 1'b0;
        @(negedge clk);
        chk("halt_if_state", 32'(state), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("halt_id_state", 32'(state), 1);
        chk("halt_id_pc_write", 32'(pc_write), 0);
        chk("halt_id_halted", 32'(is_halted), 0);
        @(posedge clk); #1;
        repeat (20) begin
            @(negedge clk);
            chk("halt_state", 32'(state), 7);
            chk("halt_flag", 32'(is_halted), 1);
            chk("halt_strobes", 32'(strobes()), 0);
            opcode = ops[$urandom_range(0, 8)];
            @(posedge clk); #1;
        end
        do_reset();
        run_instr(OP_LD, 1'b0, 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
